// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select sequencer.
// Includes the modulo-4 select increment used in both modes.
package mux_sel_pkg;

    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_MAX = 2'd3;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_t;

    // Step the select, wrapping from the last mux input back to the first.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
        return (cur == SEL_MAX) ? '0 : SEL_W'(cur + 1'b1);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises, debounces and edge-detects one active-low push-key.
// Emits a single-cycle press pulse on each accepted 1->0 transition.
module key_debouncer #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    // The counter tops out at DB_CYCLES-1; the next differing sample flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            db_cnt <= '0;
        end else if (sync_q[1] == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            stable <= sync_q[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Drives the 4-to-1 mux select from two debounced keys, either stepping
// on each "next" press (manual) or scanning on a fixed period (auto).
module mux_select_sequencer
    import mux_sel_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SCAN_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_next_n,
    input  logic             key_mode_n,
    output logic [SEL_W-1:0] s,
    output logic             auto,
    output logic             sel_changed
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic              next_press;
    logic              mode_press;
    mode_t             state;
    logic [SCAN_W-1:0] scan_cnt;

    key_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_next_key (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_next_n),
        .press(next_press)
    );

    key_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_mode_key (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_mode_n),
        .press(mode_press)
    );

    // A mode press outranks a coincident next press, and never touches s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MODE_MANUAL;
            s           <= '0;
            auto        <= 1'b0;
            sel_changed <= 1'b0;
            scan_cnt    <= '0;
        end else begin
            sel_changed <= 1'b0;
            if (mode_press) begin
                scan_cnt <= '0;
                if (state == MODE_MANUAL) begin
                    state <= MODE_AUTO;
                    auto  <= 1'b1;
                end else begin
                    state <= MODE_MANUAL;
                    auto  <= 1'b0;
                end
            end else begin
                case (state)
                    MODE_MANUAL: begin
                        scan_cnt <= '0;
                        if (next_press) begin
                            s           <= next_sel(s);
                            sel_changed <= 1'b1;
                        end
                    end
                    MODE_AUTO: begin
                        if (scan_cnt == SCAN_LAST) begin
                            s           <= next_sel(s);
                            sel_changed <= 1'b1;
                            scan_cnt    <= '0;
                        end else begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= MODE_MANUAL;
                        scan_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Scoreboard bench: every press queues the output changes it should cause,
// and a monitor pops one entry for each cycle in which the outputs move.
module tb_mux_select_sequencer;

    localparam int DB  = 4;
    localparam int SCN = 8;
    localparam int LAT = DB + 4;

    typedef struct {
        int cyc;
        int s_v;
        int auto_v;
        int sel_v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_next_n;
    logic       key_mode_n;
    logic [1:0] s;
    logic       auto;
    logic       sel_changed;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   prev_s = 0;
    int   prev_auto = 0;
    exp_t sb_q[$];

    mux_select_sequencer #(
        .DB_CYCLES  (DB),
        .SCAN_CYCLES(SCN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_next_n (key_next_n),
        .key_mode_n (key_mode_n),
        .s          (s),
        .auto       (auto),
        .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    endtask

    task automatic pushExp(input int c, input int sv, input int av, input int scv);
        exp_t e;
        e.cyc = c; e.s_v = sv; e.auto_v = av; e.sel_v = scv;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; the next rising edge is edge 0 of the press.
    task automatic applyStimulus(input bit nxt, input bit mode, output int start);
        start = cyc;
        if (nxt)  key_next_n = 1'b0;
        if (mode) key_mode_n = 1'b0;
    endtask

    task automatic releaseKeys(input int hold);
        repeat (hold) @(negedge clk);
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !mon_en) begin
            prev_s    = int'(s);
            prev_auto = int'(auto);
        end else if (int'(s) != prev_s || int'(auto) != prev_auto || sel_changed) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_s", int'(s), prev_s);
                checkOutput("spurious_auto", int'(auto), prev_auto);
                checkOutput("spurious_sel", int'(sel_changed), 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("evt_cycle", cyc, e.cyc);
                checkOutput("evt_s", int'(s), e.s_v);
                checkOutput("evt_auto", int'(auto), e.auto_v);
                checkOutput("evt_sel", int'(sel_changed), e.sel_v);
            end
            prev_s    = int'(s);
            prev_auto = int'(auto);
        end
    end

    initial begin
        int n;
        int e;
        rst_n      = 1'b0;
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
        #2;
        checkOutput("rst_s", int'(s), 0);
        checkOutput("rst_auto", int'(auto), 0);
        checkOutput("rst_sel", int'(sel_changed), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] manual presses and wrap");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, n);
            pushExp(n + LAT, k % 4, 0, 1);
            releaseKeys(10);
            repeat (15) @(negedge clk);
        end

        $display("[TB] bounce rejection");
        for (int k = 0; k < 20; k++) begin
            key_next_n = 1'b0;
            repeat (3) @(negedge clk);
            key_next_n = 1'b1;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checkOutput("bounce_s", int'(s), 0);

        $display("[TB] auto scan");
        applyStimulus(1'b0, 1'b1, n);
        e = n + LAT;
        pushExp(e, 0, 1, 0);
        for (int k = 1; k <= 4; k++) pushExp(e + k * SCN, k % 4, 1, 1);
        pushExp(e + 4 * SCN + 4, 0, 0, 0);
        releaseKeys(10);
        waitUntil(e + 2);
        applyStimulus(1'b1, 1'b0, n);
        releaseKeys(10);
        waitUntil(e + 4 * SCN + 4 - LAT);
        applyStimulus(1'b0, 1'b1, n);
        releaseKeys(10);
        repeat (30) @(negedge clk);
        checkOutput("frozen_s", int'(s), 0);
        checkOutput("frozen_auto", int'(auto), 0);

        $display("[TB] simultaneous keys then reset mid-auto");
        applyStimulus(1'b1, 1'b1, n);
        e = n + LAT;
        pushExp(e, 0, 1, 0);
        pushExp(e + SCN, 1, 1, 1);
        pushExp(e + 2 * SCN, 2, 1, 1);
        releaseKeys(10);
        waitUntil(e + 2 * SCN + 2);
        checkOutput("pre_rst_s", int'(s), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_s", int'(s), 0);
        checkOutput("async_rst_auto", int'(auto), 0);
        checkOutput("async_rst_sel", int'(sel_changed), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("post_rst_s", int'(s), 0);
        checkOutput("post_rst_auto", int'(auto), 0);
        checkOutput("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
